door_lock_controller: RTL and testbench
=======================================

DOOR_LOCK_CONTROLLER -- requirements
Module: door_lock_controller

Interface
REQ-001 SHALL have parameter DEFAULT_PW, default 12'h123, password loaded at reset (3 BCD-style nibbles, first-entered digit in [11:8]).
REQ-002 SHALL have parameter UNLOCK_CYCLES, default 16, cycle count the door stays unlocked.
REQ-003 SHALL have parameter LOCKOUT_CYCLES, default 32, cycle count of alarm lockout.
REQ-004 SHALL have parameter MAX_FAILS, default 3, consecutive wrong entries that trigger lockout.
REQ-005 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_digit  input  4  keypad digit, sampled only when i_confirm=1.
REQ-008 SHALL have port i_confirm  input  1  one-cycle strobe accepting i_digit.
REQ-009 SHALL have port i_enter  input  1  one-cycle strobe submitting the collected entry.
REQ-010 SHALL have port i_lock  input  1  one-cycle strobe relocking while unlocked.
REQ-011 SHALL have port i_set_mode  input  1  one-cycle strobe entering password-change mode while unlocked.
REQ-012 SHALL have port o_unlocked  output  1  high exactly while state is UNLOCKED or SET_NEW.
REQ-013 SHALL have port o_alarm  output  1  high exactly while state is ALARM.
REQ-014 SHALL have port o_state  output  3  current state encoding.
REQ-015 SHALL have port o_digits  output  2  digits collected, saturating at 3.
REQ-016 SHALL have port o_fails  output  2  consecutive failed attempts.

Function
REQ-017 SHALL implement states LOCKED, CHECK, UNLOCKED, SET_NEW, ALARM; all outputs registered.
REQ-018 In LOCKED/SET_NEW, i_confirm SHALL shift i_digit into a 12-bit entry register (entry <= entry<<4 | digit, oldest nibble dropped) and increment o_digits, saturating at 3; visible the next cycle.
REQ-019 In LOCKED, i_enter SHALL move to CHECK next cycle; i_confirm in the same cycle as i_enter SHALL be discarded.
REQ-020 CHECK SHALL last one cycle: match = (o_digits==3 and entry==stored password).
REQ-021 On match, CHECK SHALL go to UNLOCKED, clear o_fails, load unlock timer with UNLOCK_CYCLES.
REQ-022 On mismatch, CHECK SHALL increment o_fails; if new value == MAX_FAILS go to ALARM loading lockout timer with LOCKOUT_CYCLES, else go to LOCKED.
REQ-023 Leaving CHECK or SET_NEW SHALL clear the entry register and o_digits.
REQ-024 In UNLOCKED, the timer SHALL decrement each cycle; o_unlocked SHALL stay high exactly UNLOCK_CYCLES cycles, then state returns to LOCKED.
REQ-025 In UNLOCKED, priority SHALL be: timer expiry > i_lock > i_set_mode; i_lock goes to LOCKED, i_set_mode goes to SET_NEW; digits and i_enter ignored.
REQ-026 In SET_NEW, timer SHALL pause; i_enter with o_digits==3 SHALL write entry to stored password and return to UNLOCKED with timer reloaded; i_enter with o_digits<3 SHALL return to UNLOCKED, password unchanged, timer reloaded.
REQ-027 In ALARM, all inputs SHALL be ignored; after LOCKOUT_CYCLES cycles state SHALL return to LOCKED with o_fails cleared.
REQ-028 Timers SHALL be sized $clog2(max(UNLOCK_CYCLES,LOCKOUT_CYCLES))+1 bits; no wrap-around.

Reset
REQ-029 i_reset SHALL, at any state including mid-entry or mid-timer, set state LOCKED, stored password DEFAULT_PW, entry 0, o_digits 0, o_fails 0, timers 0, o_unlocked 0, o_alarm 0.
REQ-030 i_reset SHALL override every concurrent strobe.

Structure
REQ-031 State encoding, DIGIT_W=4, PW_W=12 and default parameter constants SHALL reside in package door_lock_pkg.
REQ-032 The entry register SHALL be one instance of password_getter_sync, reset by i_reset OR a controller clear pulse; its data input is i_digit and its confirm input is gated by state.

Verification
REQ-033 Reset, enter 1,2,3 then i_enter -> o_unlocked rises 2 cycles after i_enter, stays 16 cycles, state back to LOCKED.
REQ-034 Enter 1,2,4 three times -> o_fails 1,2 then ALARM; o_alarm high 32 cycles; digits during ALARM ignored; o_fails 0 after.
REQ-035 Unlock, i_set_mode, enter 7,8,9, i_enter, i_lock; enter 1,2,3 -> fail; enter 7,8,9 -> unlock.
REQ-036 Enter 9,1,2,3 (four digits) -> o_digits stays 3, entry 0x123 -> unlock; enter 1,2 then i_enter -> fail.
REQ-037 Simultaneous i_lock and i_set_mode in UNLOCKED -> LOCKED; i_confirm with i_enter -> digit discarded.
REQ-038 i_reset asserted mid-UNLOCKED after password change -> LOCKED; 1,2,3 unlocks again.

Source files
------------

// File: rtl/door_lock_pkg.sv
// rtl/door_lock_pkg.sv - state encoding and shared constants for the door lock controller
package door_lock_pkg;

    localparam int DIGIT_W    = 4;
    localparam int PW_W       = 12;
    localparam int NUM_DIGITS = PW_W / DIGIT_W;

    localparam logic [PW_W-1:0] DEFAULT_PW_C     = 12'h123;
    localparam int              UNLOCK_CYCLES_C  = 16;
    localparam int              LOCKOUT_CYCLES_C = 32;
    localparam int              MAX_FAILS_C      = 3;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_SET_NEW  = 3'd3,
        ST_ALARM    = 3'd4
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/password_getter_sync.sv
// rtl/password_getter_sync.sv - keypad entry shift register with saturating digit count
module password_getter_sync
    import door_lock_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_confirm,
    output logic [PW_W-1:0]    o_entry,
    output logic [1:0]         o_count
);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_entry <= '0;
            o_count <= '0;
        end else if (i_confirm) begin
            // Oldest digit falls off the top so the last three entered always count.
            o_entry <= {o_entry[PW_W-DIGIT_W-1:0], i_digit};
            if (o_count != 2'(NUM_DIGITS))
                o_count <= o_count + 2'd1;
        end
    end

endmodule

// File: rtl/door_lock_controller.sv
// rtl/door_lock_controller.sv - keypad door lock FSM with unlock timer, password change and alarm lockout
module door_lock_controller
    import door_lock_pkg::*;
#(
    parameter logic [PW_W-1:0] DEFAULT_PW     = DEFAULT_PW_C,
    parameter int              UNLOCK_CYCLES  = UNLOCK_CYCLES_C,
    parameter int              LOCKOUT_CYCLES = LOCKOUT_CYCLES_C,
    parameter int              MAX_FAILS      = MAX_FAILS_C
)(
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [DIGIT_W-1:0] i_digit,
    input  logic               i_confirm,
    input  logic               i_enter,
    input  logic               i_lock,
    input  logic               i_set_mode,
    output logic               o_unlocked,
    output logic               o_alarm,
    output logic [2:0]         o_state,
    output logic [1:0]         o_digits,
    output logic [1:0]         o_fails
);

    localparam int TIMER_W = $clog2(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES)) + 1;
    localparam logic [TIMER_W-1:0] UNLOCK_T  = TIMER_W'(UNLOCK_CYCLES);
    localparam logic [TIMER_W-1:0] LOCKOUT_T = TIMER_W'(LOCKOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    state_t             state;
    logic [PW_W-1:0]    stored_pw;
    logic [PW_W-1:0]    entry;
    logic [TIMER_W-1:0] timer;
    logic               entry_clear;
    logic               entry_confirm;
    logic               match;
    logic [1:0]         fails_inc;

    // The entry is wiped on the same edge that leaves CHECK or SET_NEW.
    assign entry_clear   = (state == ST_CHECK) || ((state == ST_SET_NEW) && i_enter);
    assign entry_confirm = i_confirm && !i_enter &&
                           ((state == ST_LOCKED) || (state == ST_SET_NEW));
    assign match         = (o_digits == 2'(NUM_DIGITS)) && (entry == stored_pw);
    assign fails_inc     = o_fails + 2'd1;
    assign o_state       = state;

    password_getter_sync u_getter (
        .i_clk     (i_clk),
        .i_reset   (i_reset || entry_clear),
        .i_digit   (i_digit),
        .i_confirm (entry_confirm),
        .o_entry   (entry),
        .o_count   (o_digits)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_LOCKED;
            stored_pw  <= DEFAULT_PW;
            o_fails    <= '0;
            timer      <= '0;
            o_unlocked <= 1'b0;
            o_alarm    <= 1'b0;
        end else begin
            case (state)
                ST_LOCKED: begin
                    if (i_enter)
                        state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (match) begin
                        state      <= ST_UNLOCKED;
                        o_fails    <= '0;
                        timer      <= UNLOCK_T;
                        o_unlocked <= 1'b1;
                    end else begin
                        o_fails <= fails_inc;
                        if (int'(fails_inc) == MAX_FAILS) begin
                            state   <= ST_ALARM;
                            timer   <= LOCKOUT_T;
                            o_alarm <= 1'b1;
                        end else begin
                            state <= ST_LOCKED;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    // Expiry wins over both user strobes.
                    if (timer <= TIMER_ONE) begin
                        state      <= ST_LOCKED;
                        timer      <= '0;
                        o_unlocked <= 1'b0;
                    end else if (i_lock) begin
                        state      <= ST_LOCKED;
                        timer      <= '0;
                        o_unlocked <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_ONE;
                        if (i_set_mode)
                            state <= ST_SET_NEW;
                    end
                end
                ST_SET_NEW: begin
                    if (i_enter) begin
                        if (o_digits == 2'(NUM_DIGITS))
                            stored_pw <= entry;
                        state <= ST_UNLOCKED;
                        timer <= UNLOCK_T;
                    end
                end
                ST_ALARM: begin
                    if (timer <= TIMER_ONE) begin
                        state   <= ST_LOCKED;
                        timer   <= '0;
                        o_fails <= '0;
                        o_alarm <= 1'b0;
                    end else begin
                        timer <= timer - TIMER_ONE;
                    end
                end
                default: begin
                    state      <= ST_LOCKED;
                    o_unlocked <= 1'b0;
                    o_alarm    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_door_lock_controller.sv
// tb/tb_door_lock_controller.sv - self-checking bench for door_lock_controller
module tb_door_lock_controller;
    import door_lock_pkg::*;

    localparam int UNLOCK  = 16;
    localparam int LOCKOUT = 32;
    localparam int MAXF    = 3;
    localparam int DEF_PW  = 'h123;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [3:0] i_digit = '0;
    logic       i_confirm = 1'b0;
    logic       i_enter = 1'b0;
    logic       i_lock = 1'b0;
    logic       i_set_mode = 1'b0;
    logic       o_unlocked;
    logic       o_alarm;
    logic [2:0] o_state;
    logic [1:0] o_digits;
    logic [1:0] o_fails;

    int n_checks = 0;
    int n_fails  = 0;

    state_t m_state = ST_LOCKED;
    int m_pw = DEF_PW, m_entry = 0, m_digits = 0, m_fails = 0, m_left = 0;

    door_lock_controller dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_digit    (i_digit),
        .i_confirm  (i_confirm),
        .i_enter    (i_enter),
        .i_lock     (i_lock),
        .i_set_mode (i_set_mode),
        .o_unlocked (o_unlocked),
        .o_alarm    (o_alarm),
        .o_state    (o_state),
        .o_digits   (o_digits),
        .o_fails    (o_fails)
    );

    always #5 i_clk = ~i_clk;

    task automatic take_digit(input logic [3:0] d);
        m_entry = (m_entry * 16 + int'(d)) % 4096;
        if (m_digits < 3) m_digits++;
    endtask

    // Behavioural model: one call per clock edge, using the inputs presented for that edge.
    task automatic model_update(input logic c, input logic [3:0] d, input logic e,
                                input logic l, input logic s, input logic r);
        if (r) begin
            m_state = ST_LOCKED; m_pw = DEF_PW; m_entry = 0; m_digits = 0; m_fails = 0; m_left = 0;
        end else begin
            case (m_state)
                ST_LOCKED: begin
                    if (e) m_state = ST_CHECK;
                    else if (c) take_digit(d);
                end
                ST_CHECK: begin
                    if (m_digits == 3 && m_entry == m_pw) begin
                        m_state = ST_UNLOCKED; m_fails = 0; m_left = UNLOCK;
                    end else begin
                        m_fails++;
                        if (m_fails == MAXF) begin
                            m_state = ST_ALARM; m_left = LOCKOUT;
                        end else begin
                            m_state = ST_LOCKED;
                        end
                    end
                    m_entry = 0; m_digits = 0;
                end
                ST_UNLOCKED: begin
                    m_left--;
                    if (m_left == 0) m_state = ST_LOCKED;
                    else if (l) m_state = ST_LOCKED;
                    else if (s) m_state = ST_SET_NEW;
                end
                ST_SET_NEW: begin
                    if (e) begin
                        if (m_digits == 3) m_pw = m_entry;
                        m_entry = 0; m_digits = 0;
                        m_state = ST_UNLOCKED; m_left = UNLOCK;
                    end else if (c) begin
                        take_digit(d);
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_state = ST_LOCKED; m_fails = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input logic c, input logic [3:0] d, input logic e,
                        input logic l, input logic s, input logic r);
        i_confirm = c; i_digit = d; i_enter = e; i_lock = l; i_set_mode = s; i_reset = r;
        model_update(c, d, e, l, s, r);
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'd0, 0, 0, 0, 0);
    endtask

    task automatic press(input logic [3:0] d);
        step(1, d, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 4'd0, 0, 0, 0, 1);
        idle(1);
    endtask

    task automatic try_code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        press(a); press(b); press(c);
        step(0, 4'd0, 1, 0, 0, 0);
        idle(1);
    endtask

    task automatic test_reset();
        step(1, 4'd5, 1, 1, 1, 1);
        n_checks++; if (o_state !== 3'(ST_LOCKED)) begin n_fails++; $display("FAIL reset_state got %0d want %0d", o_state, ST_LOCKED); end
        n_checks++; if (o_unlocked !== 1'b0) begin n_fails++; $display("FAIL reset_unlocked got %b want 0", o_unlocked); end
        n_checks++; if (o_alarm !== 1'b0) begin n_fails++; $display("FAIL reset_alarm got %b want 0", o_alarm); end
        n_checks++; if (o_digits !== 2'd0) begin n_fails++; $display("FAIL reset_digits got %0d want 0", o_digits); end
        n_checks++; if (o_fails !== 2'd0) begin n_fails++; $display("FAIL reset_fails got %0d want 0", o_fails); end
    endtask

    task automatic test_unlock();
        int cnt;
        do_reset();
        press(1); press(2); press(3);
        n_checks++; if (o_digits !== 2'd3) begin n_fails++; $display("FAIL unlock_digits got %0d want 3", o_digits); end
        step(0, 4'd0, 1, 0, 0, 0);
        n_checks++; if (o_state !== 3'(ST_CHECK) || o_unlocked !== 1'b0) begin n_fails++; $display("FAIL unlock_check got state %0d unl %b want %0d 0", o_state, o_unlocked, ST_CHECK); end
        idle(1);
        n_checks++; if (o_unlocked !== 1'b1) begin n_fails++; $display("FAIL unlock_rise got %b want 1", o_unlocked); end
        cnt = 1;
        for (int g = 0; g < 60 && o_unlocked === 1'b1; g++) begin
            idle(1);
            if (o_unlocked === 1'b1) cnt++;
        end
        n_checks++; if (cnt != UNLOCK) begin n_fails++; $display("FAIL unlock_duration got %0d want %0d", cnt, UNLOCK); end
        n_checks++; if (o_state !== 3'(ST_LOCKED)) begin n_fails++; $display("FAIL unlock_relock got %0d want %0d", o_state, ST_LOCKED); end
    endtask

    task automatic test_lockout();
        int cnt;
        do_reset();
        for (int a = 1; a < MAXF; a++) begin
            try_code(1, 2, 4);
            n_checks++; if (o_fails !== 2'(a) || o_state !== 3'(ST_LOCKED)) begin n_fails++; $display("FAIL lockout_fails got %0d/%0d want %0d/%0d", o_fails, o_state, a, ST_LOCKED); end
        end
        try_code(1, 2, 4);
        n_checks++; if (o_alarm !== 1'b1 || o_state !== 3'(ST_ALARM)) begin n_fails++; $display("FAIL lockout_alarm got %b/%0d want 1/%0d", o_alarm, o_state, ST_ALARM); end
        cnt = 1;
        for (int g = 0; g < 100 && o_alarm === 1'b1; g++) begin
            step(1, 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1, 1, 0);
            if (o_alarm === 1'b1) begin
                cnt++;
                n_checks++; if (o_digits !== 2'd0) begin n_fails++; $display("FAIL lockout_ignore got %0d want 0", o_digits); end
            end
        end
        n_checks++; if (cnt != LOCKOUT) begin n_fails++; $display("FAIL lockout_duration got %0d want %0d", cnt, LOCKOUT); end
        n_checks++; if (o_fails !== 2'd0 || o_state !== 3'(ST_LOCKED)) begin n_fails++; $display("FAIL lockout_exit got %0d/%0d want 0/%0d", o_fails, o_state, ST_LOCKED); end
    endtask

    task automatic test_set_mode();
        do_reset();
        try_code(1, 2, 3);
        step(0, 4'd0, 0, 0, 1, 0);
        n_checks++; if (o_state !== 3'(ST_SET_NEW) || o_unlocked !== 1'b1) begin n_fails++; $display("FAIL setmode_enter got %0d/%b want %0d/1", o_state, o_unlocked, ST_SET_NEW); end
        try_code(7, 8, 9);
        n_checks++; if (o_state !== 3'(ST_UNLOCKED) || o_digits !== 2'd0) begin n_fails++; $display("FAIL setmode_exit got %0d/%0d want %0d/0", o_state, o_digits, ST_UNLOCKED); end
        step(0, 4'd0, 0, 1, 0, 0);
        try_code(1, 2, 3);
        n_checks++; if (o_fails !== 2'd1 || o_unlocked !== 1'b0) begin n_fails++; $display("FAIL setmode_old_pw got %0d/%b want 1/0", o_fails, o_unlocked); end
        try_code(7, 8, 9);
        n_checks++; if (o_unlocked !== 1'b1 || o_fails !== 2'd0) begin n_fails++; $display("FAIL setmode_new_pw got %b/%0d want 1/0", o_unlocked, o_fails); end
    endtask

    task automatic test_extra_digits();
        do_reset();
        press(9); press(1); press(2); press(3);
        n_checks++; if (o_digits !== 2'd3) begin n_fails++; $display("FAIL extra_saturate got %0d want 3", o_digits); end
        step(0, 4'd0, 1, 0, 0, 0);
        idle(1);
        n_checks++; if (o_unlocked !== 1'b1) begin n_fails++; $display("FAIL extra_unlock got %b want 1", o_unlocked); end
        step(0, 4'd0, 0, 1, 0, 0);
        press(1); press(2);
        step(0, 4'd0, 1, 0, 0, 0);
        idle(1);
        n_checks++; if (o_fails !== 2'd1 || o_state !== 3'(ST_LOCKED)) begin n_fails++; $display("FAIL extra_short got %0d/%0d want 1/%0d", o_fails, o_state, ST_LOCKED); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        try_code(1, 2, 3);
        step(0, 4'd0, 0, 1, 1, 0);
        n_checks++; if (o_state !== 3'(ST_LOCKED) || o_unlocked !== 1'b0) begin n_fails++; $display("FAIL lock_vs_set got %0d/%b want %0d/0", o_state, o_unlocked, ST_LOCKED); end
        press(1); press(2);
        step(1, 4'd3, 1, 0, 0, 0);
        n_checks++; if (o_digits !== 2'd2) begin n_fails++; $display("FAIL confirm_with_enter got %0d want 2", o_digits); end
        idle(1);
        n_checks++; if (o_fails !== 2'd1 || o_unlocked !== 1'b0) begin n_fails++; $display("FAIL discard_result got %0d/%b want 1/0", o_fails, o_unlocked); end
    endtask

    task automatic test_reset_mid_unlock();
        do_reset();
        try_code(1, 2, 3);
        step(0, 4'd0, 0, 0, 1, 0);
        try_code(7, 8, 9);
        idle(3);
        step(1, 4'd4, 1, 1, 1, 1);
        n_checks++; if (o_state !== 3'(ST_LOCKED) || o_unlocked !== 1'b0 || o_digits !== 2'd0) begin n_fails++; $display("FAIL midreset got %0d/%b/%0d want %0d/0/0", o_state, o_unlocked, o_digits, ST_LOCKED); end
        try_code(1, 2, 3);
        n_checks++; if (o_unlocked !== 1'b1) begin n_fails++; $display("FAIL midreset_default_pw got %b want 1", o_unlocked); end
    endtask

    task automatic test_random();
        logic [8:0] got, exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 45), 4'($urandom_range(1, 3)),
                 1'($urandom_range(0, 99) < 12), 1'($urandom_range(0, 99) < 3),
                 1'($urandom_range(0, 99) < 6), 1'($urandom_range(0, 999) < 4));
            got = {o_state, o_unlocked, o_alarm, o_digits, o_fails};
            exp = {3'(m_state), (m_state == ST_UNLOCKED) || (m_state == ST_SET_NEW),
                   m_state == ST_ALARM, m_digits[1:0], m_fails[1:0]};
            n_checks++; if (got !== exp) begin n_fails++; $display("FAIL random_cycle%0d got %h want %h", i, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_set_mode();
        test_extra_digits();
        test_back_to_back();
        test_reset_mid_unlock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
